// File: rtl/grf_pkg.sv
// Shared sizing, index/counter types and constants for the GRF scoreboard.
package grf_pkg;

  localparam int unsigned NREG    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage : grf_pkg

// File: rtl/grf_scoreboard_if.sv
// Issue / writeback / status bundle between the pipeline and the GRF scoreboard.
//   master : decode + writeback side (drives issue_*, wb_*, flush)
//   slave  : scoreboard (drives stall, issue_fire, busy_mask, err)
interface grf_scoreboard_if
  import grf_pkg::*;
  ();

  logic             issue_valid;
  reg_idx_t         issue_rs;
  logic             issue_use_rs;
  reg_idx_t         issue_rt;
  logic             issue_use_rt;
  logic             issue_wen;
  reg_idx_t         issue_dst;
  logic             stall;
  logic             issue_fire;
  logic             wb_valid;
  reg_idx_t         wb_dst;
  logic             flush;
  logic [NREG-1:0]  busy_mask;
  logic             err;

  modport master (
    output issue_valid, issue_rs, issue_use_rs, issue_rt, issue_use_rt,
           issue_wen, issue_dst, wb_valid, wb_dst, flush,
    input  stall, issue_fire, busy_mask, err
  );

  modport slave (
    input  issue_valid, issue_rs, issue_use_rs, issue_rt, issue_use_rt,
           issue_wen, issue_dst, wb_valid, wb_dst, flush,
    output stall, issue_fire, busy_mask, err
  );

endinterface : grf_scoreboard_if

// File: rtl/grf_scoreboard_sb_counter.sv
// Per-register in-flight write counter (saturating up/down, synchronous clear).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_inc / i_dec  : issue / writeback event for this register
//   i_clr          : flush, overrides inc/dec
//   o_cnt          : registered count
//   o_nonzero_c    : count != 0
//   o_underflow_c  : decrement requested while empty (no matching increment)
module sb_counter
  import grf_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_inc,
  input  logic    i_dec,
  input  logic    i_clr,
  output sb_cnt_t o_cnt,
  output logic    o_nonzero_c,
  output logic    o_underflow_c
);

  sb_cnt_t r_cnt;

  // Simultaneous inc and dec cancel; inc saturates, dec floors at zero.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != sb_cnt_t'(CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt         = r_cnt;
  assign o_nonzero_c   = (r_cnt != '0);
  assign o_underflow_c = i_dec && !i_inc && !i_clr && (r_cnt == '0);

endmodule : sb_counter

// File: rtl/grf_scoreboard.sv
// Issue-stage scoreboard for the 32x32 GRF: tracks in-flight writes per
// register and stalls decode on RAW hazards or a saturated destination count.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   sb         : slave side of grf_scoreboard_if (issue, writeback, flush,
//                stall, issue_fire, busy_mask, sticky err)
module grf_scoreboard
  import grf_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  grf_scoreboard_if.slave sb
);

  sb_cnt_t         w_cnt [NREG];
  logic [NREG-1:0] w_nonzero;
  logic [NREG-1:0] w_underflow;
  logic            w_raw_rs;
  logic            w_raw_rt;
  logic            w_sat;
  logic            w_stall;
  logic            w_fire;
  logic            r_err;

  // Register 0 is hardwired: never pending, never errors.
  assign w_cnt[0]       = '0;
  assign w_nonzero[0]   = 1'b0;
  assign w_underflow[0] = 1'b0;

  // Hazards look only at registered counts; no same-cycle writeback bypass.
  assign w_raw_rs = sb.issue_use_rs && (sb.issue_rs != REG_ZERO) && (w_cnt[sb.issue_rs] != '0);
  assign w_raw_rt = sb.issue_use_rt && (sb.issue_rt != REG_ZERO) && (w_cnt[sb.issue_rt] != '0);
  assign w_sat    = sb.issue_wen && (sb.issue_dst != REG_ZERO) &&
                    (w_cnt[sb.issue_dst] == sb_cnt_t'(CNT_MAX));

  assign w_stall = sb.issue_valid && (w_raw_rs || w_raw_rt || w_sat);
  assign w_fire  = sb.issue_valid && !w_stall && !sb.flush;

  // One counter per tracked register; index decode done here.
  for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
    logic w_inc;
    logic w_dec;

    assign w_inc = w_fire && sb.issue_wen && (sb.issue_dst == REG_AW'(gi));
    assign w_dec = sb.wb_valid && (sb.wb_dst == REG_AW'(gi));

    sb_counter u_cnt (
      .clk           (clk),
      .reset         (reset),
      .i_inc         (w_inc),
      .i_dec         (w_dec),
      .i_clr         (sb.flush),
      .o_cnt         (w_cnt[gi]),
      .o_nonzero_c   (w_nonzero[gi]),
      .o_underflow_c (w_underflow[gi])
    );
  end

  // Sticky protocol error: writeback to a register with nothing in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (|w_underflow) begin
      r_err <= 1'b1;
    end
  end

  assign sb.stall      = w_stall;
  assign sb.issue_fire = w_fire;
  assign sb.busy_mask  = w_nonzero;
  assign sb.err        = r_err;

endmodule : grf_scoreboard
